mult_controller: RTL
====================

Name: mult_controller

Overview:
- Sequencing FSM for the shift-add multiplier.
- Drives the datapath strobes LOAD, ADD and SHIFT.
- Drives the bit counter's RESET and DECREMENT inputs, and reads back its 3-bit count to end the operation.
- Sits between the top-level start/done handshake and the datapath/counter pair. Default operand width is 4 bits (counter preloads 4).

Parameters:
COUNT_W, 3, width of the count input from the bit counter.

Ports:
clk  input  1  system clock, rising edge
n_reset  input  1  asynchronous active-low reset
START  input  1  request a multiply; sampled only in IDLE
Q0  input  1  LSB of the multiplier register from the datapath
count  input  COUNT_W  current value of the bit counter
RESET  output  1  to counter: preload to 4
DECREMENT  output  1  to counter: count <= count-1
LOAD  output  1  datapath: load operands, clear accumulator
ADD  output  1  datapath: accumulator += multiplicand
SHIFT  output  1  datapath: shift accumulator/multiplier right by one
BUSY  output  1  high in every state except IDLE
DONE  output  1  one-cycle pulse: product valid in datapath
state  output  3  current state encoding, for debug

Behaviour:
- Interface (already decided): one clock (clk); reset is asynchronous and active-low (n_reset).
- Reset: async on n_reset low, state <= IDLE. All outputs 0 while in reset, regardless of clk.
- Reset mid-operation aborts immediately; the datapath result is undefined and no DONE is issued.
- Encoding: IDLE=0, LOAD=1, TEST=2, ADD=3, SHIFT=4, DONE=5. Codes 6 and 7 are illegal and go to IDLE on the next edge with all strobes 0.
- Outputs are Moore, decoded from state only (no input-to-output combinational path):
  - IDLE: all 0.
  - LOAD: LOAD=1, RESET=1.
  - TEST: no strobes.
  - ADD: ADD=1.
  - SHIFT: SHIFT=1, DECREMENT=1.
  - DONE: DONE=1.
  - BUSY=1 in states 1-5.
- RESET and DECREMENT are never high in the same cycle; the counter ignores that combination.
- Transitions:
  - IDLE: START=1 -> LOAD, else stay.
  - LOAD -> TEST.
  - TEST: count==0 -> DONE (safety). Else Q0=1 -> ADD, Q0=0 -> SHIFT.
  - ADD -> SHIFT.
  - SHIFT: count<=1 -> DONE (this edge takes the counter to 0), else -> TEST.
  - DONE -> IDLE unconditionally.
- Q0 is sampled in TEST. The datapath guarantees Q0 reflects the post-shift multiplier by then.
- count is compared as unsigned COUNT_W bits. No wrap handling is needed, because DECREMENT is never issued at count==0.
- START is ignored while BUSY. A START held high through DONE starts a new operation one cycle after the return to IDLE (IDLE sees START=1).
- Latency, with edge 0 being the edge where START is sampled in IDLE:
  - Each multiplier bit costs 2 cycles if 0, 3 cycles if 1.
  - DONE is high in cycle 10 + (number of 1 bits in the 4-bit multiplier).
  - Range: 10 to 14 cycles.

Test Plan:
- Reset: n_reset low mid-cycle with FSM in ADD -> state=0 and all outputs 0 immediately without a clock edge. After release, FSM stays in IDLE until START.
- Multiplier 0000 (Q0 always 0), START one cycle, counter model attached -> strobes LOAD, then (TEST, SHIFT) x4. DECREMENT pulses 4 times, count 4->0, DONE in cycle 10, BUSY high cycles 1-10.
- Multiplier 1111 (Q0 always 1) -> (TEST, ADD, SHIFT) x4, 4 ADD pulses, DONE in cycle 14, DONE width exactly 1.
- Multiplier 1010 with datapath model, 0110*1010 -> ADD on bits 1 and 3 only, DONE in cycle 12, datapath product 60.
- START held high continuously -> back-to-back operations, each LOAD separated from the previous DONE by exactly one IDLE cycle. START pulses while BUSY cause no extra LOAD.
- Force count=0 in TEST, and separately force state=6 -> DONE next cycle, and IDLE next cycle, respectively. Across all tests, RESET&DECREMENT never both high (assertion).

Source files
------------

// File: rtl/mult_controller.sv
// rtl/mult_controller.sv - sequencing FSM for the shift-add multiplier datapath
module mult_controller #(
    parameter int COUNT_W = 3
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               START,
    input  logic               Q0,
    input  logic [COUNT_W-1:0] count,
    output logic               RESET,
    output logic               DECREMENT,
    output logic               LOAD,
    output logic               ADD,
    output logic               SHIFT,
    output logic               BUSY,
    output logic               DONE,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_TEST  = 3'd2,
        ST_ADD   = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Plain vector so the unused codes 6 and 7 remain representable and recoverable.
    logic [2:0] state_q;
    state_t     state_d;

    // State register; reset aborts any operation in flight without issuing DONE.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; illegal codes fall back to IDLE.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = START ? ST_LOAD : ST_IDLE;
            ST_LOAD:  state_d = ST_TEST;
            ST_TEST: begin
                if (count == '0) begin
                    state_d = ST_DONE;
                end else if (Q0) begin
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_ADD:   state_d = ST_SHIFT;
            // The decrement issued in this state takes the counter from 1 to 0.
            ST_SHIFT: state_d = (count <= COUNT_W'(1)) ? ST_DONE : ST_TEST;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Moore output decode: strobes depend on the current state only.
    always_comb begin
        RESET     = 1'b0;
        DECREMENT = 1'b0;
        LOAD      = 1'b0;
        ADD       = 1'b0;
        SHIFT     = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                LOAD  = 1'b1;
                RESET = 1'b1;
                BUSY  = 1'b1;
            end
            ST_TEST: begin
                BUSY = 1'b1;
            end
            ST_ADD: begin
                ADD  = 1'b1;
                BUSY = 1'b1;
            end
            ST_SHIFT: begin
                SHIFT     = 1'b1;
                DECREMENT = 1'b1;
                BUSY      = 1'b1;
            end
            ST_DONE: begin
                DONE = 1'b1;
                BUSY = 1'b1;
            end
            default: begin
                BUSY = 1'b0;
            end
        endcase
    end

    assign state = state_q;

endmodule
